// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared types and helpers for the adder-tree scheduler.
// Id width follows REQ_COUNT; the scheduler's NUM_REQ must not exceed it.
package adder_tree_pkg;

  localparam int REQ_COUNT = 2;
  localparam int REQ_ID_W  = $clog2(REQ_COUNT);

  function automatic int sum_width(input int data_width,
                                   input int num_operands);
    return data_width + $clog2(num_operands);
  endfunction

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/adder_tree_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of one eligible requester,
// searching upward from ptr and wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Walk offsets from far to near so the nearest eligible wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: shares one pipelined adder tree between requesters.
// Optional counters: define ADDER_TREE_SCHED_PERF_EN.
module adder_tree_sched
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_OPERANDS = 4,
  parameter int TREE_LATENCY = 3,
  parameter int NUM_REQ      = REQ_COUNT,
  localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, NUM_OPERANDS),
  localparam int VEC_W       = NUM_OPERANDS * DATA_WIDTH
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*VEC_W-1:0]     req_operands,
  output logic                         tree_in_valid,
  output logic [VEC_W-1:0]             tree_in_data,
  input  logic                         tree_out_valid,
  input  logic [SUM_WIDTH-1:0]         tree_out_sum,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*SUM_WIDTH-1:0] rsp_sum,
`ifdef ADDER_TREE_SCHED_PERF_EN
  output logic [31:0]                  perf_issue_cnt,
  output logic [31:0]                  perf_busy_cycles,
  output logic [NUM_REQ*32-1:0]        perf_stall_cnt,
`endif
  output logic                         err
);

  localparam int IDW = $bits(req_id_t);

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_idx;
  req_id_t            rr_ptr;
  req_id_t            next_ptr;
  req_id_t            issue_id;
  logic               any_grant;
  logic               capture;
  tag_t               tag_pipe [TREE_LATENCY];
  tag_t               tag_out;

  assign eligible = req_valid & ~busy;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = ARESET ? '0 : grant;
  assign any_grant = |req_ready;
  assign next_ptr  = (int'(grant_idx) == NUM_REQ - 1) ?
                     '0 : grant_idx + req_id_t'(1);
  assign tag_out   = tag_pipe[TREE_LATENCY-1];
  assign capture   = tree_out_valid && tag_out.valid;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      busy          <= '0;
      rr_ptr        <= '0;
      issue_id      <= '0;
      tree_in_valid <= 1'b0;
      tree_in_data  <= '0;
      rsp_valid     <= '0;
      rsp_sum       <= '0;
      err           <= 1'b0;
      for (int i = 0; i < TREE_LATENCY; i++)
        tag_pipe[i] <= '0;
    end else begin
      tree_in_valid <= any_grant;
      if (any_grant) begin
        rr_ptr       <= next_ptr;
        issue_id     <= grant_idx;
        tree_in_data <= req_operands[int'(grant_idx)*VEC_W +: VEC_W];
      end
      tag_pipe[0] <= {tree_in_valid, issue_id};
      for (int i = 1; i < TREE_LATENCY; i++)
        tag_pipe[i] <= tag_pipe[i-1];
      // A result without its tag, or a tag without a result, is dropped.
      if (tree_out_valid != tag_out.valid)
        err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture && int'(tag_out.id) == i) begin
          rsp_valid[i] <= 1'b1;
          rsp_sum[i*SUM_WIDTH +: SUM_WIDTH] <= tree_out_sum;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (req_ready[i])
          busy[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i])
          busy[i] <= 1'b0;
      end
    end
  end

`ifdef ADDER_TREE_SCHED_PERF_EN
  logic any_tag;

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < TREE_LATENCY; i++)
      any_tag = any_tag | tag_pipe[i].valid;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      perf_issue_cnt   <= '0;
      perf_busy_cycles <= '0;
      perf_stall_cnt   <= '0;
    end else begin
      if (any_grant)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (any_tag)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && !req_ready[i])
          perf_stall_cnt[i*32 +: 32] <= perf_stall_cnt[i*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: doc/adder_tree_sched.md
Name: adder_tree_sched

Overview:
- Scheduler that shares one pipelined adder-tree datapath between NUM_REQ requesters.
- Requesters are the AXI-lite register front end (requester 0) and a streaming operand port (requester 1).
- Grants are round-robin. The block issues operand vectors into the tree and tracks in-flight operations with a tag pipeline. Each sum is routed back to the requester that issued it through a per-requester result slot with valid/ready handshake.
- Sits between the AXI-lite slave register bank and the adder-tree core.

Parameters:
- DATA_WIDTH, 32: width of each operand.
- NUM_OPERANDS, 4: adder-tree inputs per operation; power of two, ≥2.
- TREE_LATENCY, 3: cycles from tree_in_valid to tree_out_valid; ≥1.
- NUM_REQ, 2: number of requesters; ≥2.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  operand vector offered, per requester.
- req_ready  out  NUM_REQ  operand vector accepted this cycle.
- req_operands  in  NUM_REQ*NUM_OPERANDS*DATA_WIDTH  flattened operands; requester i occupies slice i.
- tree_in_valid  out  1  issue strobe to the tree.
- tree_in_data  out  NUM_OPERANDS*DATA_WIDTH  operands to the tree.
- tree_out_valid  in  1  tree result strobe.
- tree_out_sum  in  SUM_WIDTH  tree result.
- rsp_valid  out  NUM_REQ  result available, per requester.
- rsp_ready  in  NUM_REQ  result consumed.
- rsp_sum  out  NUM_REQ*SUM_WIDTH  per-requester result slot.
- err  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Widths: SUM_WIDTH = DATA_WIDTH + clog2(NUM_OPERANDS), which is 34 at defaults. No truncation or saturation anywhere.
- Reset values: req_ready=0, tree_in_valid=0, tree_in_data=0, rsp_valid=0, rsp_sum=0, err=0. Reset also clears busy flags, the tag pipe and the round-robin pointer.
- Reset mid-operation: all in-flight operations are discarded; no rsp_valid is produced for them.
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0. Each requester has at most one operation outstanding, counted from grant until its response handshake.
- Arbitration:
  - Round-robin; search starts at last_grant+1 and wraps modulo NUM_REQ.
  - At most one grant per cycle.
  - req_ready is combinational: one-hot on the granted eligible requester, otherwise zero.
  - Grant occurs when req_valid[i] && req_ready[i]; last_grant updates on grant.
- Busy flags: busy[i] sets on grant and clears on rsp_valid[i] && rsp_ready[i]. A requester may re-request on the cycle after that handshake.
- Issue:
  - Cycle after grant: tree_in_valid=1 for exactly one cycle; tree_in_data is the registered slice of the granted requester.
  - tree_in_data holds its value while tree_in_valid=0.
- Tag pipe:
  - Shift register of depth TREE_LATENCY carrying {valid, id}; loaded with {tree_in_valid, granted id}.
  - The pipe output is aligned with tree_out_valid.
- Result capture:
  - On tree_out_valid with tag valid: register rsp_sum[id] and set rsp_valid[id] on the next edge.
  - rsp_valid[id] and rsp_sum[id] hold until rsp_ready[id].
- Protocol errors: any of the following sets err sticky (cleared only by ARESET) and the result is dropped:
  - tree_out_valid without a valid tag;
  - a valid tag without tree_out_valid.
- Latency: grant edge to rsp_valid = TREE_LATENCY+2 cycles (5 at defaults).
- Throughput: one issue per cycle across requesters. A single requester issues once per round trip.
- Simultaneous events:
  - Grant and response handshake for different requesters in the same cycle are independent.
  - Capture into a slot can never coincide with a pending result in that slot, because busy blocks re-issue.

Optional Feature:
- Macro: ADDER_TREE_SCHED_PERF_EN.
- When defined, the block adds:
  - perf_issue_cnt (out, 32): total grants;
  - perf_busy_cycles (out, 32): cycles with any tag valid;
  - perf_stall_cnt (out, NUM_REQ*32): cycles where req_valid[i]=1 and req_ready[i]=0.
- All three counters wrap modulo 2^32 and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package adder_tree_pkg holds:
  - the sum_width(data_width, num_operands) function;
  - typedef req_id_t = logic [clog2(NUM_REQ)-1:0];
  - typedef tag_t = struct {valid, req_id_t id}.
- One sub-module, rr_arbiter: parameter N; inputs eligible[N] and the pointer; outputs one-hot grant and the granted index.

Test Plan:
- Single op: req0 operands {1,2,3,4} → tree_in_valid 1 cycle after grant; rsp_valid[0] 5 cycles after grant with rsp_sum[0]=10; rsp_valid[1] stays 0.
- Contention: both requesters valid continuously, rsp_ready=1, req1 operands {5,5,5,5} → grants alternate 0,1,0,1 starting with 0 after reset; rsp_sum[1]=20.
- Overflow width: all operands 0xFFFFFFFF → rsp_sum=0x3FFFFFFFC (34-bit), no truncation.
- Backpressure: hold rsp_ready[0]=0 for 10 cycles → rsp_valid[0] and rsp_sum[0] stable, req_ready[0]=0 throughout, req1 still served; after release, req0 is granted the cycle after the handshake.
- Reset mid-flight: ARESET for 1 cycle 2 cycles after a grant → no rsp_valid afterwards, err=0, all outputs at reset values.
- Stray result: tree_out_valid pulsed with no op in flight → err=1 and remains 1 until ARESET.
